// File: rtl/tag_array_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tag_array_ctrl_pkg
//   Shared cache definitions used by the tag array controller, the tag array
//   wrapper and the L1 controller.
//   - TAG_W_DEF / IDX_W_DEF : default tag and index widths
//   - op_e                  : request operation encoding
//   - state_e               : tag controller FSM states
//   - op_is_lookup()        : reserved op 11 is handled as a lookup
// -----------------------------------------------------------------------------
package tag_array_ctrl_pkg;

    localparam int TAG_W_DEF = 22;
    localparam int IDX_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_FILL   = 2'b01,
        OP_INVAL  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic op_is_lookup(input op_e op);
        return (op == OP_LOOKUP) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/tag_array_ctrl.sv
// -----------------------------------------------------------------------------
// tag_array_ctrl
//   Initiator side of the cache tag SRAM. Accepts lookup / fill / invalidate
//   requests (valid/ready), runs one SRAM access cycle, then returns a single
//   cycle response. Per-line valid bits live in flops here, not in the SRAM.
//
//   Ports
//     clk, rst          : clock (rising edge), async active-high reset
//     req_*             : request handshake, op, index, tag
//     resp_*            : one-cycle response strobe, hit flag, stored tag
//     tag_CS/OE/WEB/A/DI: SRAM control, address and write data
//     tag_DO            : SRAM read data, valid the cycle after a read
//     stat_hit_cnt/stat_miss_cnt : saturating lookup counters
//                                  (present only with TAG_STAT_EN defined)
//
//   Sequence: IDLE (accept) -> ACCESS (drive SRAM) -> RESP (respond) -> IDLE.
// -----------------------------------------------------------------------------
module tag_array_ctrl
    import tag_array_ctrl_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [TAG_W-1:0] resp_tag,
    output logic             tag_CS,
    output logic             tag_OE,
    output logic             tag_WEB,
    output logic [IDX_W-1:0] tag_A,
    output logic [TAG_W-1:0] tag_DI,
`ifdef TAG_STAT_EN
    output logic [31:0]      stat_hit_cnt,
    output logic [31:0]      stat_miss_cnt,
`endif
    input  logic [TAG_W-1:0] tag_DO
);

    localparam int DEPTH = 1 << IDX_W;

    state_e           state_q;
    op_e              op_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [DEPTH-1:0] valid_q;

    // Control FSM; valid bits change on the edge that ends the ACCESS cycle,
    // so a lookup issued right after a fill already sees the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOOKUP;
            idx_q   <= '0;
            tag_q   <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_e'(req_op);
                        idx_q   <= req_idx;
                        tag_q   <= req_tag;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (op_q == OP_FILL)
                        valid_q[idx_q] <= 1'b1;
                    else if (op_q == OP_INVAL)
                        valid_q[idx_q] <= 1'b0;
                    state_q <= ST_RESP;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);

    // SRAM pins and response are decoded from state + capture registers.
    // The response cannot be registered: tag_DO only arrives in RESP.
    always_comb begin
        tag_CS     = 1'b0;
        tag_OE     = 1'b0;
        tag_WEB    = 1'b1;
        tag_A      = '0;
        tag_DI     = '0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_tag   = '0;
        case (state_q)
            ST_ACCESS: begin
                if (op_is_lookup(op_q)) begin
                    tag_CS = 1'b1;
                    tag_OE = 1'b1;
                    tag_A  = idx_q;
                end else if (op_q == OP_FILL) begin
                    tag_CS  = 1'b1;
                    tag_WEB = 1'b0;
                    tag_A   = idx_q;
                    tag_DI  = tag_q;
                end
                // invalidate touches only the valid bit; SRAM stays idle
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (op_is_lookup(op_q)) begin
                    resp_hit = valid_q[idx_q] && (tag_DO == tag_q);
                    resp_tag = tag_DO;
                end
            end
            default: ;
        endcase
    end

`ifdef TAG_STAT_EN
    logic lookup_resp;
    assign lookup_resp = (state_q == ST_RESP) && op_is_lookup(op_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else if (lookup_resp) begin
            if (resp_hit) begin
                if (stat_hit_cnt != 32'hFFFF_FFFF)
                    stat_hit_cnt <= stat_hit_cnt + 32'd1;
            end else begin
                if (stat_miss_cnt != 32'hFFFF_FFFF)
                    stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
